obstacle_spawner: RTL and testbench

- Owns the falling-obstacle table for the 2-Cars game.
- Consumes the 5-bit pseudo-random word from the fibonacci LFSR and a once-per-frame tick from the VGA timing logic.
- Scrolls every live obstacle down each frame, retires obstacles that leave the screen, and spawns new ones into random lanes.
- The pixel renderer in top reads the table through a registered read port.

---
 rtl/obstacle_spawner.sv | 227 ++++++++++++++++++++++
 tb/tb_obstacle_spawner.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/obstacle_spawner.sv
// Falling-obstacle table for the 2-Cars game: scrolls live slots once per frame,
// retires those that leave the screen and spawns new ones into random lanes.
module obstacle_spawner #(
    parameter int NUM_SLOTS = 8,
    parameter int SCREEN_H  = 480,
    parameter int SPEED     = 2,
    parameter int SPAWN_GAP = 96
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       frame_tick,
    input  logic [4:0] rnd,
    input  logic       run,
    input  logic       clear,
    input  logic [3:0] rd_idx,
    output logic       rd_valid,
    output logic [1:0] rd_lane,
    output logic       rd_kind,
    output logic [9:0] rd_y,
    output logic       busy,
    output logic       exit_pulse,
    output logic [1:0] exit_lane,
    output logic       exit_kind,
    output logic       spawn_drop,
    output logic       overrun
);
    localparam int IDX_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SLOTS - 1);

    typedef enum logic [1:0] {IDLE, SCAN, SPAWN} state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [9:0]       gap_q, gap_d;
    logic             valid_q [NUM_SLOTS];
    logic             valid_d [NUM_SLOTS];
    logic [1:0]       lane_q  [NUM_SLOTS];
    logic [1:0]       lane_d  [NUM_SLOTS];
    logic             kind_q  [NUM_SLOTS];
    logic             kind_d  [NUM_SLOTS];
    logic [9:0]       y_q     [NUM_SLOTS];
    logic [9:0]       y_d     [NUM_SLOTS];

    logic       rd_valid_q, rd_valid_d;
    logic [1:0] rd_lane_q, rd_lane_d;
    logic       rd_kind_q, rd_kind_d;
    logic [9:0] rd_y_q, rd_y_d;
    logic       busy_q, busy_d;
    logic       exit_pulse_q, exit_pulse_d;
    logic [1:0] exit_lane_q, exit_lane_d;
    logic       exit_kind_q, exit_kind_d;
    logic       spawn_drop_q, spawn_drop_d;
    logic       overrun_q, overrun_d;

    logic             free_found;
    logic [IDX_W-1:0] free_idx;
    logic [10:0]      ny;

    function automatic logic [9:0] sat_gap_add(input logic [9:0] g);
        logic [10:0] s;
        s = {1'b0, g} + 11'(SPEED);
        return (s > 11'd1023) ? 10'd1023 : s[9:0];
    endfunction

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        gap_d        = gap_q;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            valid_d[i] = valid_q[i];
            lane_d[i]  = lane_q[i];
            kind_d[i]  = kind_q[i];
            y_d[i]     = y_q[i];
        end
        exit_pulse_d = 1'b0;
        exit_lane_d  = exit_lane_q;
        exit_kind_d  = exit_kind_q;
        spawn_drop_d = 1'b0;
        overrun_d    = overrun_q;

        // Lowest-index free slot wins, so scan downward and keep the last hit.
        free_found = 1'b0;
        free_idx   = '0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (!valid_q[i]) begin
                free_found = 1'b1;
                free_idx   = IDX_W'(i);
            end
        end
        ny = {1'b0, y_q[idx_q]} + 11'(SPEED);

        if (frame_tick && run && state_q != IDLE)
            overrun_d = 1'b1;

        case (state_q)
            IDLE: begin
                if (frame_tick && run) begin
                    state_d = SCAN;
                    idx_d   = '0;
                end
            end
            SCAN: begin
                if (valid_q[idx_q]) begin
                    if (ny >= 11'(SCREEN_H)) begin
                        valid_d[idx_q] = 1'b0;
                        exit_pulse_d   = 1'b1;
                        exit_lane_d    = lane_q[idx_q];
                        exit_kind_d    = kind_q[idx_q];
                    end else begin
                        y_d[idx_q] = ny[9:0];
                    end
                end
                if (idx_q == LAST_IDX) begin
                    gap_d   = sat_gap_add(gap_q);
                    state_d = SPAWN;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            SPAWN: begin
                if (gap_q >= 10'(SPAWN_GAP)) begin
                    if (free_found) begin
                        valid_d[free_idx] = 1'b1;
                        lane_d[free_idx]  = rnd[1:0];
                        kind_d[free_idx]  = rnd[2];
                        y_d[free_idx]     = '0;
                        gap_d             = '0;
                    end else begin
                        spawn_drop_d = 1'b1;
                    end
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);

        if ({1'b0, rd_idx} < 5'(NUM_SLOTS)) begin
            rd_valid_d = valid_q[rd_idx[IDX_W-1:0]];
            rd_lane_d  = lane_q[rd_idx[IDX_W-1:0]];
            rd_kind_d  = kind_q[rd_idx[IDX_W-1:0]];
            rd_y_d     = y_q[rd_idx[IDX_W-1:0]];
        end else begin
            rd_valid_d = 1'b0;
            rd_lane_d  = '0;
            rd_kind_d  = 1'b0;
            rd_y_d     = '0;
        end

        // Restart flush overrides everything, including an in-flight scan.
        if (clear) begin
            state_d = IDLE;
            idx_d   = '0;
            gap_d   = 10'(SPAWN_GAP);
            for (int i = 0; i < NUM_SLOTS; i++) begin
                valid_d[i] = 1'b0;
                lane_d[i]  = '0;
                kind_d[i]  = 1'b0;
                y_d[i]     = '0;
            end
            exit_pulse_d = 1'b0;
            spawn_drop_d = 1'b0;
            overrun_d    = 1'b0;
            busy_d       = 1'b0;
            rd_valid_d   = 1'b0;
            rd_lane_d    = '0;
            rd_kind_d    = 1'b0;
            rd_y_d       = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            gap_q        <= 10'(SPAWN_GAP);
            for (int i = 0; i < NUM_SLOTS; i++) begin
                valid_q[i] <= 1'b0;
                lane_q[i]  <= '0;
                kind_q[i]  <= 1'b0;
                y_q[i]     <= '0;
            end
            rd_valid_q   <= 1'b0;
            rd_lane_q    <= '0;
            rd_kind_q    <= 1'b0;
            rd_y_q       <= '0;
            busy_q       <= 1'b0;
            exit_pulse_q <= 1'b0;
            exit_lane_q  <= '0;
            exit_kind_q  <= 1'b0;
            spawn_drop_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            gap_q        <= gap_d;
            for (int i = 0; i < NUM_SLOTS; i++) begin
                valid_q[i] <= valid_d[i];
                lane_q[i]  <= lane_d[i];
                kind_q[i]  <= kind_d[i];
                y_q[i]     <= y_d[i];
            end
            rd_valid_q   <= rd_valid_d;
            rd_lane_q    <= rd_lane_d;
            rd_kind_q    <= rd_kind_d;
            rd_y_q       <= rd_y_d;
            busy_q       <= busy_d;
            exit_pulse_q <= exit_pulse_d;
            exit_lane_q  <= exit_lane_d;
            exit_kind_q  <= exit_kind_d;
            spawn_drop_q <= spawn_drop_d;
            overrun_q    <= overrun_d;
        end
    end

    assign rd_valid   = rd_valid_q;
    assign rd_lane    = rd_lane_q;
    assign rd_kind    = rd_kind_q;
    assign rd_y       = rd_y_q;
    assign busy       = busy_q;
    assign exit_pulse = exit_pulse_q;
    assign exit_lane  = exit_lane_q;
    assign exit_kind  = exit_kind_q;
    assign spawn_drop = spawn_drop_q;
    assign overrun    = overrun_q;
endmodule

// File: tb/tb_obstacle_spawner.sv
// Bench for obstacle_spawner: two instances (normal gap and a tiny gap that fills
// the table) driven by random frames and compared against a frame-level table model.
module tb_obstacle_spawner;
    localparam int N  = 8;
    localparam int H  = 480;
    localparam int SP = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, frame_tick, run, clear;
    logic [4:0] rnd;
    logic [3:0] rd_idx;

    logic [1:0]      rdv, rdk, bsy, exv, exk, drp, ovr;
    logic [1:0][1:0] rdl, exl;
    logic [1:0][9:0] rdy;

    obstacle_spawner #(.NUM_SLOTS(N), .SCREEN_H(H), .SPEED(SP), .SPAWN_GAP(96)) dut0 (
        .clk(clk), .rst(rst), .frame_tick(frame_tick), .rnd(rnd), .run(run), .clear(clear),
        .rd_idx(rd_idx), .rd_valid(rdv[0]), .rd_lane(rdl[0]), .rd_kind(rdk[0]), .rd_y(rdy[0]),
        .busy(bsy[0]), .exit_pulse(exv[0]), .exit_lane(exl[0]), .exit_kind(exk[0]),
        .spawn_drop(drp[0]), .overrun(ovr[0]));

    obstacle_spawner #(.NUM_SLOTS(N), .SCREEN_H(H), .SPEED(SP), .SPAWN_GAP(2)) dut1 (
        .clk(clk), .rst(rst), .frame_tick(frame_tick), .rnd(rnd), .run(run), .clear(clear),
        .rd_idx(rd_idx), .rd_valid(rdv[1]), .rd_lane(rdl[1]), .rd_kind(rdk[1]), .rd_y(rdy[1]),
        .busy(bsy[1]), .exit_pulse(exv[1]), .exit_lane(exl[1]), .exit_kind(exk[1]),
        .spawn_drop(drp[1]), .overrun(ovr[1]));

    int gap_cfg [2] = '{96, 2};
    int m_valid [2][N];
    int m_lane  [2][N];
    int m_kind  [2][N];
    int m_y     [2][N];
    int m_gap   [2];
    int m_over  [2];

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic m_flush(input int d);
        for (int s = 0; s < N; s++) begin
            m_valid[d][s] = 0;
            m_lane[d][s]  = 0;
            m_kind[d][s]  = 0;
            m_y[d][s]     = 0;
        end
        m_gap[d]  = gap_cfg[d];
        m_over[d] = 0;
    endtask

    // One frame of the game: scroll/retire the first nproc slots; a partial frame ends in a flush.
    task automatic m_frame(input int d, input int nproc, input int r,
                           output int cnt, output int seq, output int drop);
        int free;
        cnt = 0; seq = 0; drop = 0;
        for (int s = 0; s < nproc; s++) begin
            if (m_valid[d][s] != 0) begin
                if (m_y[d][s] + SP >= H) begin
                    m_valid[d][s] = 0;
                    cnt++;
                    seq = seq * 8 + m_lane[d][s] * 2 + m_kind[d][s];
                end else begin
                    m_y[d][s] += SP;
                end
            end
        end
        if (nproc < N) begin
            m_flush(d);
        end else begin
            m_gap[d] = (m_gap[d] + SP > 1023) ? 1023 : m_gap[d] + SP;
            if (m_gap[d] >= gap_cfg[d]) begin
                free = -1;
                for (int s = 0; s < N; s++)
                    if (m_valid[d][s] == 0 && free < 0) free = s;
                if (free >= 0) begin
                    m_valid[d][free] = 1;
                    m_lane[d][free]  = r % 4;
                    m_kind[d][free]  = (r / 4) % 2;
                    m_y[d][free]     = 0;
                    m_gap[d]         = 0;
                end else begin
                    drop = 1;
                end
            end
        end
    endtask

    task automatic check_table(input string ph);
        for (int s = 0; s < 16; s++) begin
            rd_idx = 4'(s);
            step();
            for (int d = 0; d < 2; d++) begin
                if (s < N) begin
                    chk($sformatf("%s_d%0d_s%0d_valid", ph, d, s), int'(rdv[d]), m_valid[d][s]);
                    if (m_valid[d][s] != 0) begin
                        chk($sformatf("%s_d%0d_s%0d_lane", ph, d, s), int'(rdl[d]), m_lane[d][s]);
                        chk($sformatf("%s_d%0d_s%0d_kind", ph, d, s), int'(rdk[d]), m_kind[d][s]);
                        chk($sformatf("%s_d%0d_s%0d_y", ph, d, s), int'(rdy[d]), m_y[d][s]);
                    end
                end else begin
                    chk($sformatf("%s_d%0d_oor%0d", ph, d, s),
                        int'({rdv[d], rdl[d], rdk[d], rdy[d]}), 0);
                end
            end
        end
    endtask

    // mode: 0 clear mid-scan, 1 extra tick mid-scan, 2 tick together with clear, else plain frame
    task automatic do_frame(input int mode, input int runv, input int r1, input int r2);
        int clear_at, nproc;
        int cnt [2];
        int seq [2];
        int drop[2];
        int ecnt, eseq, edrop;
        rnd = 5'(r1);
        run = 1'(runv);
        if (mode == 2) begin
            frame_tick = 1'b1; clear = 1'b1;
            step();
            frame_tick = 1'b0; clear = 1'b0;
            for (int d = 0; d < 2; d++) begin
                chk($sformatf("tickclr_busy_d%0d", d), int'(bsy[d]), 0);
                m_flush(d);
                chk($sformatf("tickclr_ovr_d%0d", d), int'(ovr[d]), 0);
            end
            return;
        end
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
        if (runv == 0) begin
            for (int k = 0; k < 3; k++) begin
                step();
                for (int d = 0; d < 2; d++) chk($sformatf("norun_busy_d%0d", d), int'(bsy[d]), 0);
            end
            return;
        end
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("start_busy_d%0d", d), int'(bsy[d]), 1);
            cnt[d] = 0; seq[d] = 0; drop[d] = 0;
        end
        clear_at = (mode == 0) ? int'($urandom_range(2, 9)) : 99;
        for (int e = 2; e <= 10; e++) begin
            if (e == 5) rnd = 5'(r2);
            run = 1'($urandom % 2);
            if (mode == 1 && e == 3) begin
                frame_tick = 1'b1;
                run = 1'b1;
            end
            if (e == clear_at) clear = 1'b1;
            step();
            frame_tick = 1'b0;
            clear = 1'b0;
            for (int d = 0; d < 2; d++) begin
                if (exv[d]) begin
                    cnt[d]++;
                    seq[d] = seq[d] * 8 + int'(exl[d]) * 2 + int'(exk[d]);
                end
                if (drp[d]) drop[d]++;
                if (e == 9 && clear_at > 9) chk($sformatf("scan_busy_d%0d", d), int'(bsy[d]), 1);
                if (e == clear_at) chk($sformatf("clr_busy_d%0d", d), int'(bsy[d]), 0);
            end
        end
        nproc = (clear_at <= 9) ? clear_at - 2 : N;
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("end_busy_d%0d", d), int'(bsy[d]), 0);
            m_frame(d, nproc, r2, ecnt, eseq, edrop);
            if (mode == 1) m_over[d] = 1;
            chk($sformatf("exit_cnt_d%0d", d), cnt[d], ecnt);
            chk($sformatf("exit_seq_d%0d", d), seq[d], eseq);
            chk($sformatf("drop_d%0d", d), drop[d], edrop);
            chk($sformatf("overrun_d%0d", d), int'(ovr[d]), m_over[d]);
        end
    endtask

    initial begin
        rst = 1'b1; frame_tick = 1'b0; run = 1'b0; clear = 1'b0; rnd = '0; rd_idx = '0;
        step();
        step();
        rst = 1'b0;
        for (int d = 0; d < 2; d++) begin
            m_flush(d);
            chk($sformatf("rst_busy_d%0d", d), int'(bsy[d]), 0);
            chk($sformatf("rst_exit_d%0d", d), int'(exv[d]), 0);
            chk($sformatf("rst_drop_d%0d", d), int'(drp[d]), 0);
            chk($sformatf("rst_ovr_d%0d", d), int'(ovr[d]), 0);
            chk($sformatf("rst_rd_d%0d", d), int'({rdv[d], rdl[d], rdk[d], rdy[d]}), 0);
        end
        for (int s = 0; s < N; s++) begin
            rd_idx = 4'(s);
            step();
            chk($sformatf("rst_y_s%0d", s), int'(rdy[0]), 0);
            chk($sformatf("rst_valid_s%0d", s), int'(rdv[0]), 0);
        end

        do_frame(3, 1, 6, 6);
        rd_idx = 4'd0;
        step();
        chk("first_valid", int'(rdv[0]), 1);
        chk("first_lane", int'(rdl[0]), 2);
        chk("first_kind", int'(rdk[0]), 1);
        chk("first_y", int'(rdy[0]), 0);
        check_table("first");

        for (int f = 0; f < 450; f++) begin
            int mode, runv;
            if (f < 280) mode = ($urandom % 20 == 0) ? 1 : 3;
            else         mode = int'($urandom % 8);
            runv = ($urandom % 10 != 0) ? 1 : 0;
            do_frame(mode, runv, int'($urandom % 32), int'($urandom % 32));
            check_table($sformatf("f%0d", f));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
